time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/time_keeper.sv | 175 +++++++++++++++++
 tb/tb_time_keeper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Real-time clock: prescaled seconds tick, BCD hh:mm:ss counters and a set mode with edge-detected adjust.
// Define CLOCK_12H_EN for a 12-hour display (12,01..11) with pm toggling on 11->12; default is 24-hour.
module time_keeper #(
    parameter int CLK_PER_SEC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setting,
    input  logic       setting_h,
    input  logic       setting_m,
    output logic [1:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [2:0] min_tens,
    output logic [3:0] min_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       sec_tick,
    output logic       pm
);
    localparam int PW = $clog2(CLK_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

`ifdef CLOCK_12H_EN
    localparam logic [1:0] HR_TENS_RST = 2'd1;
    localparam logic [3:0] HR_ONES_RST = 4'd2;
`else
    localparam logic [1:0] HR_TENS_RST = 2'd0;
    localparam logic [3:0] HR_ONES_RST = 4'd0;
`endif

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    hr_tens_q, hr_tens_d;
    logic [3:0]    hr_ones_q, hr_ones_d;
    logic [2:0]    min_tens_q, min_tens_d;
    logic [3:0]    min_ones_q, min_ones_d;
    logic [2:0]    sec_tens_q, sec_tens_d;
    logic [3:0]    sec_ones_q, sec_ones_d;
    logic          sec_tick_q, sec_tick_d;
    logic          pm_q, pm_d;
    logic          sh_q, sh_d;
    logic          sm_q, sm_d;

    logic [7:0]    sec_n;
    logic [7:0]    min_n;
    logic [5:0]    hr_n;
    logic          h_rise;
    logic          m_rise;
    logic          hr_step;

    // Returns {carry, tens, ones} for a 00..59 BCD field.
    function automatic logic [7:0] sixty_inc(input logic [2:0] tens, input logic [3:0] ones);
        logic [7:0] r;
        if (ones != 4'd9) begin
            r = {1'b0, tens, ones + 4'd1};
        end else if (tens != 3'd5) begin
            r = {1'b0, tens + 3'd1, 4'd0};
        end else begin
            r = {1'b1, 3'd0, 4'd0};
        end
        return r;
    endfunction

    function automatic logic [5:0] hour_inc(input logic [1:0] tens, input logic [3:0] ones);
        logic [5:0] r;
`ifdef CLOCK_12H_EN
        if (tens == 2'd1 && ones == 4'd2) begin
            r = {2'd0, 4'd1};
        end else if (ones == 4'd9) begin
            r = {2'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
`else
        if (tens == 2'd2 && ones == 4'd3) begin
            r = {2'd0, 4'd0};
        end else if (ones == 4'd9) begin
            r = {tens + 2'd1, 4'd0};
        end else begin
            r = {tens, ones + 4'd1};
        end
`endif
        return r;
    endfunction

    always_comb begin
        sec_n      = sixty_inc(sec_tens_q, sec_ones_q);
        min_n      = sixty_inc(min_tens_q, min_ones_q);
        hr_n       = hour_inc(hr_tens_q, hr_ones_q);
        h_rise     = setting_h & ~sh_q;
        m_rise     = setting_m & ~sm_q;

        presc_d    = presc_q;
        hr_tens_d  = hr_tens_q;
        hr_ones_d  = hr_ones_q;
        min_tens_d = min_tens_q;
        min_ones_d = min_ones_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        sec_tick_d = 1'b0;
`ifdef CLOCK_12H_EN
        pm_d       = pm_q;
`else
        pm_d       = 1'b0;
`endif
        sh_d       = setting_h;
        sm_d       = setting_m;
        hr_step    = 1'b0;

        if (setting) begin
            // Set mode: time base frozen, seconds pinned, minute adjust never carries into hours.
            presc_d    = '0;
            sec_tens_d = 3'd0;
            sec_ones_d = 4'd0;
            if (m_rise) begin
                {min_tens_d, min_ones_d} = min_n[6:0];
            end
            hr_step = h_rise;
        end else if (presc_q == PRESC_LAST) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            {sec_tens_d, sec_ones_d} = sec_n[6:0];
            if (sec_n[7]) begin
                {min_tens_d, min_ones_d} = min_n[6:0];
                hr_step = min_n[7];
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end

        if (hr_step) begin
            {hr_tens_d, hr_ones_d} = hr_n;
`ifdef CLOCK_12H_EN
            pm_d = pm_q ^ (hr_tens_q == 2'd1 && hr_ones_q == 4'd1);
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            hr_tens_q  <= HR_TENS_RST;
            hr_ones_q  <= HR_ONES_RST;
            min_tens_q <= 3'd0;
            min_ones_q <= 4'd0;
            sec_tens_q <= 3'd0;
            sec_ones_q <= 4'd0;
            sec_tick_q <= 1'b0;
            pm_q       <= 1'b0;
            sh_q       <= 1'b0;
            sm_q       <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            hr_tens_q  <= hr_tens_d;
            hr_ones_q  <= hr_ones_d;
            min_tens_q <= min_tens_d;
            min_ones_q <= min_ones_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            sec_tick_q <= sec_tick_d;
            pm_q       <= pm_d;
            sh_q       <= sh_d;
            sm_q       <= sm_d;
        end
    end

    assign hr_tens  = hr_tens_q;
    assign hr_ones  = hr_ones_q;
    assign min_tens = min_tens_q;
    assign min_ones = min_ones_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign sec_tick = sec_tick_q;
    assign pm       = pm_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper at CLK_PER_SEC=4; time is compared as 24'hHHMMSS.
module tb_time_keeper;
    localparam int CPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       setting = 1'b0;
    logic       setting_h = 1'b0;
    logic       setting_m = 1'b0;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic       sec_tick;
    logic       pm;

    int vectors = 0;
    int miscompares = 0;
    int set_bad = 0;
    int bcd_bad = 0;
    logic set_at_edge = 1'b0;

    always #5 clk = ~clk;

    time_keeper #(.CLK_PER_SEC(CPS)) dut (
        .clk      (clk),
        .rst      (rst),
        .setting  (setting),
        .setting_h(setting_h),
        .setting_m(setting_m),
        .hr_tens  (hr_tens),
        .hr_ones  (hr_ones),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .sec_tick (sec_tick),
        .pm       (pm)
    );

    function automatic logic [23:0] now_t();
        return {2'b00, hr_tens, hr_ones, 1'b0, min_tens, min_ones, 1'b0, sec_tens, sec_ones};
    endfunction

    // Background monitors: seconds pinned in set mode, digits always legal BCD.
    always @(posedge clk) set_at_edge <= setting && !rst;

    always @(negedge clk) begin
        if (set_at_edge && (sec_tens != 3'd0 || sec_ones != 4'd0 || sec_tick))
            set_bad <= set_bad + 1;
`ifdef CLOCK_12H_EN
        if (hr_tens > 2'd1 || (hr_tens == 2'd1 && hr_ones > 4'd2) || (hr_tens == 2'd0 && hr_ones == 4'd0) ||
`else
        if (hr_tens > 2'd2 || (hr_tens == 2'd2 && hr_ones > 4'd3) ||
`endif
            hr_ones > 4'd9 || min_tens > 3'd5 || min_ones > 4'd9 || sec_tens > 3'd5 || sec_ones > 4'd9)
            bcd_bad <= bcd_bad + 1;
    end

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vector %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    task automatic pulse_h(input int n);
        repeat (n) begin
            setting_h = 1'b1;
            @(negedge clk);
            setting_h = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic pulse_m(input int n);
        repeat (n) begin
            setting_m = 1'b1;
            @(negedge clk);
            setting_m = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int ticks;
        int dbl;
        logic prev;
        logic [23:0] t;

        repeat (2) @(negedge clk);
`ifdef CLOCK_12H_EN
        chk("rst_time", now_t(), 24'h120000);
`else
        chk("rst_time", now_t(), 24'h000000);
`endif
        chk("rst_tick", 24'(sec_tick), 24'd0);
        chk("rst_pm", 24'(pm), 24'd0);
        rst = 1'b0;

`ifdef CLOCK_12H_EN
        setting = 1'b1;
        @(negedge clk);
        chk("set12_start", now_t(), 24'h120000);
        pulse_h(11);
        chk("set12_hours", now_t(), 24'h110000);
        chk("set12_pm", 24'(pm), 24'd0);
        pulse_m(59);
        setting = 1'b0;
        repeat (59 * CPS) @(negedge clk);
        chk("run12_115959", now_t(), 24'h115959);
        chk("run12_am", 24'(pm), 24'd0);
        repeat (CPS) @(negedge clk);
        chk("run12_noon", now_t(), 24'h120000);
        chk("run12_pm", 24'(pm), 24'd1);
        setting = 1'b1;
        pulse_h(1);
        chk("set12_one", now_t(), 24'h010000);
        chk("set12_pm_kept", 24'(pm), 24'd1);
        setting = 1'b0;
`else
        ticks = 0;
        dbl = 0;
        prev = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (sec_tick) begin
                ticks++;
                if (prev) dbl++;
            end
            prev = sec_tick;
        end
        chk("run16_time", now_t(), 24'h000004);
        chk("run16_ticks", 24'(ticks), 24'd4);
        chk("tick_width", 24'(dbl), 24'd0);

        setting = 1'b1;
        @(negedge clk);
        chk("set_sec_zero", now_t(), 24'h000000);
        pulse_h(23);
        pulse_m(59);
        chk("preload_hm", now_t(), 24'h235900);
        setting = 1'b0;
        repeat (58 * CPS) @(negedge clk);
        chk("preload_run", now_t(), 24'h235958);
        repeat (CPS) @(negedge clk);
        chk("t_235959", now_t(), 24'h235959);
        repeat (CPS - 1) @(negedge clk);
        chk("pre_wrap", now_t(), 24'h235959);
        @(negedge clk);
        chk("wrap", now_t(), 24'h000000);
        chk("wrap_tick", 24'(sec_tick), 24'd1);

        setting = 1'b1;
        pulse_h(3);
        pulse_m(61);
        chk("set_3h61m", now_t(), 24'h030100);
        setting = 1'b0;
        repeat (CPS - 1) @(negedge clk);
        chk("restart_quiet", 24'(sec_tick), 24'd0);
        @(negedge clk);
        chk("restart_tick", 24'(sec_tick), 24'd1);
        chk("restart_time", now_t(), 24'h030101);

        setting = 1'b1;
        setting_h = 1'b1;
        repeat (20) @(negedge clk);
        setting_h = 1'b0;
        @(negedge clk);
        setting = 1'b0;
        pulse_h(3);
        chk("held_h_once", now_t(), 24'h040101);

        setting = 1'b1;
        setting_h = 1'b1;
        setting_m = 1'b1;
        @(negedge clk);
        setting_h = 1'b0;
        setting_m = 1'b0;
        @(negedge clk);
        chk("both_edges", now_t(), 24'h050200);
        pulse_m(8);
        setting = 1'b0;
        repeat (20 * CPS) @(negedge clk);
        chk("pre_reset", now_t(), 24'h051020);

        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        t = now_t();
        chk("async_rst", t, 24'h000000);
        chk("async_rst_tick", 24'(sec_tick), 24'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (CPS - 1) @(negedge clk);
        chk("rst_quiet", 24'(sec_tick), 24'd0);
        @(negedge clk);
        chk("rst_first_tick", 24'(sec_tick), 24'd1);
        chk("rst_first_time", now_t(), 24'h000001);
        chk("pm_tied", 24'(pm), 24'd0);
`endif

        @(negedge clk);
        chk("set_hold", 24'(set_bad), 24'd0);
        chk("bcd_legal", 24'(bcd_bad), 24'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
